// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the cache read-channel arbiter.
package axi_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_e;

   localparam logic [2:0] RD_BYTE = 3'b000;
   localparam logic [2:0] RD_HALF = 3'b001;
   localparam logic [2:0] RD_WORD = 3'b010;
   localparam logic [2:0] RD_LINE = 3'b100;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [3:0] LEN_LINE   = 4'hf;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_fields_t;

   // Anything that is not a line read is a single beat sized by type[1:0].
   function automatic ar_fields_t ar_encode(input logic [3:0]  id,
                                            input logic [31:0] addr,
                                            input logic [2:0]  rd_type);
      ar_fields_t f;
      f.id    = id;
      f.addr  = addr;
      f.burst = BURST_INCR;
      if (rd_type == RD_LINE) begin
         f.len  = LEN_LINE;
         f.size = SIZE_WORD;
      end else begin
         f.len  = 4'h0;
         f.size = {1'b0, rd_type[1:0]};
      end
      return f;
   endfunction

endpackage

// File: rtl/arb_grant.sv
// Priority pick between the cache refill requests: dcache first, with a
// saturating count that forces an icache grant after STARVE_MAX dcache wins.
module arb_grant #(
   parameter int STARVE_MAX = 4
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic grant_en,
   input  logic ic_req,
   input  logic dc_req,
   output logic grant_ic,
   output logic grant_dc
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;
   logic          ic_forced;

   assign ic_forced = ic_req && (starve_cnt == STARVE_LIM);
   assign grant_dc  = dc_req && !ic_forced;
   assign grant_ic  = ic_req && !grant_dc;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         starve_cnt <= '0;
      end else if (grant_en) begin
         if (grant_ic) begin
            starve_cnt <= '0;
         end else if (grant_dc && ic_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the icache and dcache refill ports.
//   state   | meaning
//   IDLE    | no transaction; arbitrate and latch the winner's AR fields
//   ADDR    | arvalid held with stable fields until arready
//   DATA    | rready high; R beats routed to the owner until rlast
module axi_rd_arbiter
   import axi_rd_pkg::*;
#(
   parameter int         STARVE_MAX = 4,
   parameter logic [3:0] ID_ICACHE  = 4'd0,
   parameter logic [3:0] ID_DCACHE  = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,

   input  logic        ic_rd_req,
   input  logic [2:0]  ic_rd_type,
   input  logic [31:0] ic_rd_addr,
   output logic        ic_rd_rdy,
   output logic        ic_ret_valid,
   output logic        ic_ret_last,
   output logic [31:0] ic_ret_data,

   input  logic        dc_rd_req,
   input  logic [2:0]  dc_rd_type,
   input  logic [31:0] dc_rd_addr,
   output logic        dc_rd_rdy,
   output logic        dc_ret_valid,
   output logic        dc_ret_last,
   output logic [31:0] dc_ret_data,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,

   output logic        rd_err
);

   rd_state_e  state, state_nxt;
   ar_fields_t ar_q;
   logic       owner_ic;
   logic       grant_ic, grant_dc, grant_any;
   logic       ar_hs, r_hs, beat_err;
   logic [3:0] beat_cnt;

   arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb_grant (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .grant_en (state == ST_IDLE),
      .ic_req   (ic_rd_req),
      .dc_req   (dc_rd_req),
      .grant_ic (grant_ic),
      .grant_dc (grant_dc)
   );

   assign grant_any = grant_ic | grant_dc;
   assign ar_hs     = (state == ST_ADDR) && arready;
   assign r_hs      = (state == ST_DATA) && rvalid;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant_any)       state_nxt = ST_ADDR;
         ST_ADDR: if (arready)         state_nxt = ST_DATA;
         ST_DATA: if (rvalid && rlast) state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      arvalid      = 1'b0;
      rready       = 1'b0;
      ic_rd_rdy    = 1'b0;
      dc_rd_rdy    = 1'b0;
      ic_ret_valid = 1'b0;
      ic_ret_last  = 1'b0;
      ic_ret_data  = '0;
      dc_ret_valid = 1'b0;
      dc_ret_last  = 1'b0;
      dc_ret_data  = '0;
      case (state)
         ST_ADDR: begin
            arvalid   = 1'b1;
            ic_rd_rdy = arready && owner_ic;
            dc_rd_rdy = arready && !owner_ic;
         end
         ST_DATA: begin
            rready = 1'b1;
            if (owner_ic) begin
               ic_ret_valid = rvalid;
               ic_ret_last  = rvalid && rlast;
               ic_ret_data  = rvalid ? rdata : '0;
            end else begin
               dc_ret_valid = rvalid;
               dc_ret_last  = rvalid && rlast;
               dc_ret_data  = rvalid ? rdata : '0;
            end
         end
         default: ;
      endcase
   end

   // AR fields are captured once at grant so they stay stable through any arready stall.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ar_q     <= '0;
         owner_ic <= 1'b0;
      end else if ((state == ST_IDLE) && grant_any) begin
         owner_ic <= grant_ic;
         ar_q     <= grant_ic ? ar_encode(ID_ICACHE, ic_rd_addr, ic_rd_type)
                              : ar_encode(ID_DCACHE, dc_rd_addr, dc_rd_type);
      end
   end

   assign arid    = ar_q.id;
   assign araddr  = ar_q.addr;
   assign arlen   = ar_q.len;
   assign arsize  = ar_q.size;
   assign arburst = ar_q.burst;

   // rlast must coincide exactly with the beat whose index equals arlen.
   assign beat_err = r_hs && ((rid != ar_q.id) ||
                              (rresp != RESP_OKAY) ||
                              (rlast != (beat_cnt == ar_q.len)));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beat_cnt <= '0;
      end else if (ar_hs) begin
         beat_cnt <= '0;
      end else if (r_hs) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_err <= 1'b0;
      end else if (beat_err) begin
         rd_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench: requester and AXI slave drivers push expectations,
// a negedge monitor pops and compares against a rule-level model.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

   localparam int STARVE_MAX = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        ic_rd_req, dc_rd_req;
   logic [2:0]  ic_rd_type, dc_rd_type;
   logic [31:0] ic_rd_addr, dc_rd_addr;
   logic        ic_rd_rdy, dc_rd_rdy;
   logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
   logic [31:0] ic_ret_data, dc_ret_data;
   logic [3:0]  arid, arlen;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready, rd_err;

   logic        req   [2];
   logic [2:0]  rtype [2];
   logic [31:0] raddr [2];
   logic        rdy   [2];

   assign ic_rd_req  = req[0];
   assign dc_rd_req  = req[1];
   assign ic_rd_type = rtype[0];
   assign dc_rd_type = rtype[1];
   assign ic_rd_addr = raddr[0];
   assign dc_rd_addr = raddr[1];
   assign rdy[0]     = ic_rd_rdy;
   assign rdy[1]     = dc_rd_rdy;

   axi_rd_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .ID_ICACHE  (4'd0),
      .ID_DCACHE  (4'd1)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .ic_rd_req    (ic_rd_req),
      .ic_rd_type   (ic_rd_type),
      .ic_rd_addr   (ic_rd_addr),
      .ic_rd_rdy    (ic_rd_rdy),
      .ic_ret_valid (ic_ret_valid),
      .ic_ret_last  (ic_ret_last),
      .ic_ret_data  (ic_ret_data),
      .dc_rd_req    (dc_rd_req),
      .dc_rd_type   (dc_rd_type),
      .dc_rd_addr   (dc_rd_addr),
      .dc_rd_rdy    (dc_rd_rdy),
      .dc_ret_valid (dc_ret_valid),
      .dc_ret_last  (dc_ret_last),
      .dc_ret_data  (dc_ret_data),
      .arid         (arid),
      .araddr       (araddr),
      .arlen        (arlen),
      .arsize       (arsize),
      .arburst      (arburst),
      .arvalid      (arvalid),
      .arready      (arready),
      .rid          (rid),
      .rdata        (rdata),
      .rresp        (rresp),
      .rlast        (rlast),
      .rvalid       (rvalid),
      .rready       (rready),
      .rd_err       (rd_err)
   );

   always #5 aclk = ~aclk;

   typedef struct {logic [2:0] rtype; logic [31:0] addr; int gap;} cmd_t;
   typedef struct {logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size;} exp_ar_t;
   typedef struct {int owner; logic [3:0] id; int nbeats;} burst_t;
   typedef struct {int owner; logic [31:0] data; logic last;} beat_t;

   cmd_t    cmd_q    [2][$];
   exp_ar_t exp_ar_q [2][$];
   burst_t  burst_q  [$];
   beat_t   beat_q   [$];
   int      grant_log[$];
   bit      pend     [2];

   int errors = 0;
   int checks = 0;

   int phase = 0;
   int owner = 0;
   int dc_run = 0;
   bit exp_err = 1'b0;

   int ar_delay = -1;
   int err_mode = 0;
   int beats_sent = 0;
   bit slave_active = 1'b0;
   logic beat_bad = 1'b0;
   int cnt_ic = 0, cnt_dc = 0, cnt_arv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   task automatic push_cmd(input int who, input logic [2:0] t, input logic [31:0] a, input int gap);
      cmd_t c;
      c.rtype = t;
      c.addr  = a;
      c.gap   = gap;
      cmd_q[who].push_back(c);
   endtask

   function automatic logic [2:0] rand_type();
      int r;
      r = int'($urandom_range(0, 5));
      if (r < 3) return 3'b100;
      return 3'(r - 3);
   endfunction

   task automatic requester(input int who);
      cmd_t    c;
      exp_ar_t e;
      int      t;
      req[who]   = 1'b0;
      rtype[who] = '0;
      raddr[who] = '0;
      pend[who]  = 1'b0;
      forever begin
         @(posedge aclk); #1;
         if (!aresetn || cmd_q[who].size() == 0) begin
            req[who] = 1'b0;
            continue;
         end
         c = cmd_q[who].pop_front();
         pend[who] = 1'b1;
         if (c.gap > 0) begin
            req[who] = 1'b0;
            repeat (c.gap) begin @(posedge aclk); #1; end
         end
         e.id   = (who == 0) ? 4'd0 : 4'd1;
         e.addr = c.addr;
         e.len  = (c.rtype == 3'b100) ? 4'd15 : 4'd0;
         e.size = (c.rtype == 3'b100) ? 3'd2 : {1'b0, c.rtype[1:0]};
         exp_ar_q[who].push_back(e);
         req[who]   = 1'b1;
         rtype[who] = c.rtype;
         raddr[who] = c.addr;
         t = 0;
         forever begin
            @(negedge aclk);
            if (!aresetn || rdy[who]) break;
            t++;
            if (t > 3000) begin
               fail($sformatf("rdy_timeout_%0d", who));
               break;
            end
         end
         pend[who] = 1'b0;
      end
   endtask

   initial requester(0);
   initial requester(1);

   // AXI slave: AR acceptance and R beat generation, including injected faults.
   initial begin
      burst_t b;
      beat_t  bt;
      int     sent, total, mode, arv_cnt;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      rid = '0; rresp = '0; rdata = '0;
      sent = 0; total = 0; mode = 0; arv_cnt = 0;
      forever begin
         @(posedge aclk); #1;
         if (!aresetn) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; beat_bad = 1'b0;
            slave_active = 1'b0; arv_cnt = 0;
            continue;
         end
         if (arvalid) arv_cnt++;
         else arv_cnt = 0;
         arready = (ar_delay < 0) ? ($urandom_range(0, 2) != 0) : (arv_cnt > ar_delay);
         if (!slave_active && burst_q.size() > 0) begin
            b = burst_q.pop_front();
            slave_active = 1'b1;
            sent = 0;
            beats_sent = 0;
            mode = err_mode;
            total = b.nbeats;
            if (mode == 1 && b.nbeats == 16) total = 8;
            if (mode == 4 && b.nbeats == 16) total = 17;
         end
         beat_bad = 1'b0;
         if (slave_active) begin
            if ($urandom_range(0, 3) != 0) begin
               sent++;
               rvalid = 1'b1;
               rdata  = $urandom;
               rid    = b.id;
               rresp  = 2'b00;
               rlast  = (sent == total);
               if (mode == 1 && b.nbeats == 16 && rlast) beat_bad = 1'b1;
               if (mode == 4 && b.nbeats == 16 && sent >= 16) beat_bad = 1'b1;
               if (mode == 2 && sent == 3) begin rid = 4'd2; beat_bad = 1'b1; end
               if (mode == 3 && sent == 3) begin rresp = 2'b10; beat_bad = 1'b1; end
               bt.owner = b.owner;
               bt.data  = rdata;
               bt.last  = rlast;
               beat_q.push_back(bt);
               beats_sent = sent;
               if (rlast) slave_active = 1'b0;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
            end
         end else begin
            rvalid = ($urandom_range(0, 4) == 0);
            rlast  = 1'($urandom_range(0, 1));
            rid    = 4'($urandom_range(0, 15));
            rresp  = 2'($urandom_range(0, 3));
            rdata  = $urandom;
         end
      end
   end

   // Monitor and reference model.
   initial begin
      exp_ar_t e;
      beat_t   bt;
      burst_t  nb;
      bit      dc_side;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            exp_ar_q[0].delete();
            exp_ar_q[1].delete();
            burst_q.delete();
            beat_q.delete();
            phase = 0; dc_run = 0; exp_err = 1'b0;
            chk("arvalid_in_reset", 32'(arvalid), 32'd0);
            chk("rd_err_in_reset", 32'(rd_err), 32'd0);
            continue;
         end
         chk("arvalid", 32'(arvalid), 32'(phase == 1));
         chk("rready", 32'(rready), 32'(phase == 2));
         chk("ic_rd_rdy", 32'(ic_rd_rdy), 32'(phase == 1 && arready && owner == 0));
         chk("dc_rd_rdy", 32'(dc_rd_rdy), 32'(phase == 1 && arready && owner == 1));
         if (arvalid) cnt_arv++;
         if (phase == 1) begin
            if (exp_ar_q[owner].size() == 0) begin
               fail("ar_no_expected_request");
            end else begin
               e = exp_ar_q[owner][0];
               chk("arid", 32'(arid), 32'(e.id));
               chk("araddr", araddr, e.addr);
               chk("arlen", 32'(arlen), 32'(e.len));
               chk("arsize", 32'(arsize), 32'(e.size));
               chk("arburst", 32'(arburst), 32'd1);
            end
         end
         if (ic_ret_valid || dc_ret_valid) begin
            if (ic_ret_valid && dc_ret_valid) fail("both_ret_valid");
            dc_side = dc_ret_valid;
            if (dc_side) cnt_dc++;
            else cnt_ic++;
            if (beat_q.size() == 0) begin
               fail("unexpected_ret_beat");
            end else begin
               bt = beat_q.pop_front();
               chk("beat_owner", 32'(dc_side), 32'(bt.owner));
               chk("beat_data", dc_side ? dc_ret_data : ic_ret_data, bt.data);
               chk("beat_last", 32'(dc_side ? dc_ret_last : ic_ret_last), 32'(bt.last));
            end
         end
         chk("rd_err", 32'(rd_err), 32'(exp_err));
         case (phase)
            0: if (req[0] || req[1]) begin
                  if (req[0] && (!req[1] || dc_run == STARVE_MAX)) begin
                     owner = 0;
                     dc_run = 0;
                  end else begin
                     owner = 1;
                     if (req[0] && dc_run < STARVE_MAX) dc_run++;
                  end
                  grant_log.push_back(owner);
                  phase = 1;
               end
            1: if (arready) begin
                  if (exp_ar_q[owner].size() > 0) begin
                     e = exp_ar_q[owner].pop_front();
                     nb.owner  = owner;
                     nb.id     = e.id;
                     nb.nbeats = int'(e.len) + 1;
                     burst_q.push_back(nb);
                  end
                  phase = 2;
               end
            default: begin
               if (rvalid && beat_bad) exp_err = 1'b1;
               if (rvalid && rlast) phase = 0;
            end
         endcase
      end
   end

   task automatic wait_idle(input int max_cycles);
      int t;
      t = 0;
      forever begin
         @(negedge aclk);
         if (cmd_q[0].size() == 0 && cmd_q[1].size() == 0 && !pend[0] && !pend[1] &&
             phase == 0 && burst_q.size() == 0 && beat_q.size() == 0 && !slave_active)
            break;
         t++;
         if (t > max_cycles) begin
            fail("wait_idle_timeout");
            break;
         end
      end
      repeat (2) @(negedge aclk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_arvalid"}, 32'(arvalid), 0);
      chk({tag, "_araddr"}, araddr, 0);
      chk({tag, "_arid"}, 32'(arid), 0);
      chk({tag, "_arlen"}, 32'(arlen), 0);
      chk({tag, "_arsize"}, 32'(arsize), 0);
      chk({tag, "_arburst"}, 32'(arburst), 0);
      chk({tag, "_rready"}, 32'(rready), 0);
      chk({tag, "_rd_err"}, 32'(rd_err), 0);
      chk({tag, "_rd_rdy"}, 32'({ic_rd_rdy, dc_rd_rdy}), 0);
      chk({tag, "_ret_valid"}, 32'({ic_ret_valid, dc_ret_valid}), 0);
      chk({tag, "_ret_last"}, 32'({ic_ret_last, dc_ret_last}), 0);
      chk({tag, "_ic_ret_data"}, ic_ret_data, 0);
      chk({tag, "_dc_ret_data"}, dc_ret_data, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pat[10];
      int t;
      exp_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      repeat (3) @(negedge aclk);
      check_all_zero("reset");
      @(posedge aclk); #2 aresetn = 1'b1;

      ar_delay = 0; cnt_ic = 0; cnt_dc = 0;
      push_cmd(1, 3'b100, 32'h1fc0_0040, 0);
      wait_idle(400);
      chk("dc_line_beats", cnt_dc, 16);
      chk("dc_line_ic_beats", cnt_ic, 0);

      cnt_dc = 0;
      push_cmd(1, 3'b000, 32'h8000_0003, 0);
      wait_idle(200);
      chk("dc_byte_beats", cnt_dc, 1);

      ar_delay = 5; cnt_arv = 0;
      push_cmd(0, 3'b010, 32'h0000_1234, 0);
      wait_idle(200);
      chk("stall_arvalid_cycles", cnt_arv, 6);
      ar_delay = -1;

      grant_log.delete();
      for (int i = 0; i < 10; i++) begin
         push_cmd(0, 3'b100, $urandom, 0);
         push_cmd(1, 3'b100, $urandom, 0);
      end
      wait_idle(4000);
      for (int i = 0; i < 10; i++) begin
         if (i < grant_log.size()) chk($sformatf("starve_grant_%0d", i), grant_log[i], exp_pat[i]);
         else fail($sformatf("starve_grant_missing_%0d", i));
      end

      for (int i = 0; i < 60; i++) begin
         push_cmd(int'($urandom_range(0, 1)), rand_type(), $urandom, int'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 15)) @(negedge aclk);
      end
      wait_idle(8000);

      for (int m = 1; m <= 4; m++) begin
         err_mode = m;
         push_cmd(int'($urandom_range(0, 1)), 3'b100, $urandom, 0);
         wait_idle(500);
         err_mode = 0;
         chk($sformatf("rd_err_mode_%0d", m), 32'(rd_err), 32'd1);
      end

      beats_sent = 0;
      push_cmd(0, 3'b100, 32'h0000_2000, 0);
      t = 0;
      while (beats_sent < 5 && t < 500) begin
         @(negedge aclk);
         t++;
      end
      if (beats_sent < 5) fail("mid_burst_wait_timeout");
      @(posedge aclk); #3 aresetn = 1'b0;
      #1 check_all_zero("mid_reset");
      repeat (2) @(negedge aclk);
      @(posedge aclk); #2 aresetn = 1'b1;

      cnt_ic = 0;
      push_cmd(0, 3'b100, 32'h0000_3000, 0);
      wait_idle(500);
      chk("post_reset_ic_beats", cnt_ic, 16);
      chk("post_reset_rd_err", 32'(rd_err), 32'd0);

      chk("left_beats", beat_q.size(), 0);
      chk("left_ar_ic", exp_ar_q[0].size(), 0);
      chk("left_ar_dc", exp_ar_q[1].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
